// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types, geometry and address-field constants for the 2-way write-back dcache controller
package dcache_pkg;
    localparam int ADDR_W         = 32;
    localparam int LINE_W         = 256;
    localparam int INDEX_W        = 4;
    localparam int TAG_W          = 23;
    localparam int WORDS_PER_LINE = 8;
    localparam int WORD_W         = 32;
    localparam int WSEL_W         = 3;
    localparam int STAG_W         = TAG_W + 2;
    localparam int VALID_BIT      = 24;
    localparam int DIRTY_BIT      = 23;
    localparam int OFF_LSB        = 2;
    localparam int IDX_LSB        = 5;
    localparam int TAG_LSB        = 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MISS,
        S_WRITEBACK,
        S_REFILL,
        S_FILL
    } state_t;

    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag, input logic [INDEX_W-1:0] idx);
        return {tag, idx, {IDX_LSB{1'b0}}};
    endfunction
endpackage

// File: rtl/dcache_line_merge.sv
// dcache_line_merge: selects one word of a cache line and builds the line with that word replaced
module dcache_line_merge
    import dcache_pkg::*;
(
    input  logic [LINE_W-1:0] i_line,
    input  logic [WSEL_W-1:0] i_sel,
    input  logic [WORD_W-1:0] i_word,
    output logic [WORD_W-1:0] o_word,
    output logic [LINE_W-1:0] o_line
);
    assign o_word = i_line[WORD_W*i_sel +: WORD_W];

    for (genvar w = 0; w < WORDS_PER_LINE; w++) begin : g_word
        assign o_line[WORD_W*w +: WORD_W] = (i_sel == WSEL_W'(w)) ? i_word : i_line[WORD_W*w +: WORD_W];
    end
endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: write-back, write-allocate controller for a 2-way 16-set dcache with write-back/refill on the memory port
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_write_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [WORD_W-1:0] cpu_data_i,
    output logic [WORD_W-1:0] cpu_data_o,
    output logic              cpu_stall_o,
    output logic              mem_req_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [INDEX_W-1:0] sram_addr_o,
    output logic [STAG_W-1:0] sram_tag_o,
    output logic [LINE_W-1:0] sram_data_o,
    output logic              sram_enable_o,
    output logic              sram_write_o,
    input  logic [STAG_W-1:0] sram_tag_i,
    input  logic [LINE_W-1:0] sram_data_i,
    input  logic              sram_hit_i
);
    state_t             r_state, w_next;
    logic [TAG_W-1:0]   w_tag;
    logic [INDEX_W-1:0] w_idx;
    logic [WSEL_W-1:0]  w_sel;
    logic [WORD_W-1:0]  w_word;
    logic [LINE_W-1:0]  w_merged, r_line, r_mem_data;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic               r_mem_req, r_mem_write;
    logic               w_idle, w_miss, w_hit_load, w_hit_store, w_ack, w_victim_dirty, w_unused;

    assign w_tag          = cpu_addr_i[ADDR_W-1:TAG_LSB];
    assign w_idx          = cpu_addr_i[TAG_LSB-1:IDX_LSB];
    assign w_sel          = cpu_addr_i[IDX_LSB-1:OFF_LSB];
    assign w_unused       = &{1'b0, cpu_addr_i[OFF_LSB-1:0]};
    assign w_idle         = r_state == S_IDLE;
    assign w_miss         = w_idle & cpu_req_i & ~sram_hit_i;
    assign w_hit_load     = ~rst_i & w_idle & cpu_req_i & ~cpu_write_i & sram_hit_i;
    assign w_hit_store    = ~rst_i & w_idle & cpu_req_i & cpu_write_i & sram_hit_i;
    assign w_ack          = mem_ack_i & r_mem_req;
    assign w_victim_dirty = sram_tag_i[VALID_BIT] & sram_tag_i[DIRTY_BIT];

    assign mem_req_o   = r_mem_req;
    assign mem_write_o = r_mem_write;
    assign mem_addr_o  = r_mem_addr;
    assign mem_data_o  = r_mem_data;
    assign sram_addr_o = w_idx;

    dcache_line_merge u_merge (
        .i_line (sram_data_i),
        .i_sel  (w_sel),
        .i_word (cpu_data_i),
        .o_word (w_word),
        .o_line (w_merged)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      w_next = w_miss ? S_MISS : S_IDLE;
            S_MISS:      w_next = w_victim_dirty ? S_WRITEBACK : S_REFILL;
            S_WRITEBACK: w_next = w_ack ? S_REFILL : S_WRITEBACK;
            S_REFILL:    w_next = w_ack ? S_FILL : S_REFILL;
            default:     w_next = S_IDLE;
        endcase
    end

    // Stall and SRAM strobes are forced low during reset so an abort releases the CPU at once
    always_comb begin
        cpu_stall_o   = ~rst_i & (~w_idle | w_miss);
        cpu_data_o    = w_hit_load ? w_word : '0;
        sram_write_o  = ~rst_i & (w_hit_store | (r_state == S_FILL));
        sram_data_o   = (r_state == S_FILL) ? r_line : w_merged;
        sram_tag_o    = {1'b1, w_hit_store, w_tag};
        sram_enable_o = cpu_req_i | ~w_idle;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mem_req   <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_data  <= '0;
            r_line      <= '0;
        end else begin
            case (r_state)
                S_MISS: begin
                    r_mem_req   <= 1'b1;
                    r_mem_write <= w_victim_dirty;
                    r_mem_addr  <= line_addr(w_victim_dirty ? sram_tag_i[TAG_W-1:0] : w_tag, w_idx);
                    if (w_victim_dirty) r_mem_data <= sram_data_i;
                end
                S_WRITEBACK: if (w_ack) begin
                    r_mem_write <= 1'b0;
                    r_mem_addr  <= line_addr(w_tag, w_idx);
                end
                S_REFILL: if (w_ack) begin
                    r_mem_req <= 1'b0;
                    r_line    <= mem_data_i;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: drives the controller against a behavioural 2-way SRAM and main memory, checking against an architectural memory image
module tb_dcache_ctrl;
    logic         clk_i, rst_i, cpu_req_i, cpu_write_i;
    logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
    logic         cpu_stall_o, mem_req_o, mem_write_o, mem_ack_i;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i;
    logic [3:0]   sram_addr_o;
    logic [24:0]  sram_tag_o, sram_tag_i;
    logic [255:0] sram_data_o, sram_data_i;
    logic         sram_enable_o, sram_write_o, sram_hit_i;

    typedef struct {
        logic         w;
        logic [31:0]  a;
        logic [255:0] l;
    } tx_t;

    int           total = 0, bad = 0, ack_delay = 5;
    logic         r_ack = 0, spur = 0;
    tx_t          txq[$];
    logic [255:0] mem  [bit [31:0]];
    logic [255:0] gold [bit [31:0]];
    logic [24:0]  s_tag [16][2];
    logic [255:0] s_dat [16][2];
    logic         s_lru [16];
    logic         s_way, h0, h1;

    dcache_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i), .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i),
        .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .mem_req_o(mem_req_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i), .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o),
        .sram_data_o(sram_data_o), .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
        .sram_tag_i(sram_tag_i), .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i)
    );

    always #5 clk_i = ~clk_i;
    assign mem_ack_i = r_ack | spur;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] dflt(input logic [31:0] a);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[32*k +: 32] = 32'hA000_0000 | (a + 32'(4*k));
        return l;
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : dflt(a);
    endfunction

    function automatic logic [255:0] gold_line(input logic [31:0] a);
        return gold.exists(a) ? gold[a] : dflt(a);
    endfunction

    // SRAM model: lookup by the CPU address, miss returns the LRU way as victim
    always_comb begin
        h0          = s_tag[cpu_addr_i[8:5]][0][24] && s_tag[cpu_addr_i[8:5]][0][22:0] == cpu_addr_i[31:9];
        h1          = s_tag[cpu_addr_i[8:5]][1][24] && s_tag[cpu_addr_i[8:5]][1][22:0] == cpu_addr_i[31:9];
        s_way       = h0 ? 1'b0 : h1 ? 1'b1 : s_lru[cpu_addr_i[8:5]];
        sram_hit_i  = h0 | h1;
        sram_tag_i  = s_tag[cpu_addr_i[8:5]][s_way];
        sram_data_i = s_dat[cpu_addr_i[8:5]][s_way];
    end

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 16; i++) begin
                s_lru[i] <= 1'b0;
                for (int j = 0; j < 2; j++) s_tag[i][j] <= '0;
            end
        end else if (sram_enable_o && sram_write_o) begin
            s_tag[sram_addr_o][s_way] <= sram_tag_o;
            s_dat[sram_addr_o][s_way] <= sram_data_o;
            s_lru[sram_addr_o]        <= ~s_way;
        end
    end

    // Memory responder: one ack pulse per transaction after ack_delay cycles
    initial begin
        int  cnt;
        tx_t t;
        cnt = 0;
        forever begin
            @(posedge clk_i);
            #1;
            if (rst_i || !mem_req_o || r_ack) begin
                r_ack = 0;
                cnt   = 0;
            end else if (cnt == ack_delay) begin
                r_ack = 1;
                t.w = mem_write_o;
                t.a = mem_addr_o;
                t.l = mem_write_o ? mem_data_o : mem_line(mem_addr_o);
                if (mem_write_o) mem[mem_addr_o] = mem_data_o;
                else mem_data_i = t.l;
                txq.push_back(t);
            end else cnt++;
        end
    end

    // Per-cycle compare against the architectural memory image
    initial begin
        int           stall_n, req_n;
        logic         prev_req, prev_ack, prev_stall, prev_wr;
        logic [31:0]  prev_addr, la;
        logic [255:0] prev_data, gl, exp;
        logic [2:0]   w;
        stall_n = 0; req_n = 0; prev_req = 0; prev_ack = 0; prev_stall = 0;
        prev_wr = 0; prev_addr = 0; prev_data = 0;
        forever begin
            @(negedge clk_i);
            la = {cpu_addr_i[31:5], 5'b0};
            w  = cpu_addr_i[4:2];
            gl = gold_line(la);
            if (rst_i) begin
                gold = mem;
                stall_n = 0; req_n = 0; prev_req = 0; prev_ack = 0; prev_stall = 0;
            end else begin
                check("sram_addr", 256'(sram_addr_o), 256'(cpu_addr_i[8:5]));
                check("sram_tag_field", 256'(sram_tag_o[22:0]), 256'(cpu_addr_i[31:9]));
                if (!cpu_req_i) begin
                    check("idle_stall", 256'(cpu_stall_o), 256'(0));
                    check("idle_sram_wr", 256'(sram_write_o), 256'(0));
                    check("idle_sram_en", 256'(sram_enable_o), 256'(0));
                    check("idle_mem_req", 256'(mem_req_o), 256'(0));
                end else begin
                    check("req_sram_en", 256'(sram_enable_o), 256'(1));
                    if (!cpu_stall_o && !cpu_write_i) begin
                        check("load_data", 256'(cpu_data_o), 256'(gl[32*w +: 32]));
                        check("load_no_wr", 256'(sram_write_o), 256'(0));
                    end
                    if (!cpu_stall_o && cpu_write_i) begin
                        exp = gl;
                        exp[32*w +: 32] = cpu_data_i;
                        check("store_wr", 256'(sram_write_o), 256'(1));
                        check("store_tag", 256'(sram_tag_o), 256'({2'b11, cpu_addr_i[31:9]}));
                        check("store_line", sram_data_o, exp);
                        gold[la] = exp;
                    end
                    if (cpu_stall_o && sram_write_o) begin
                        check("fill_tag", 256'(sram_tag_o), 256'({2'b10, cpu_addr_i[31:9]}));
                        check("fill_line", sram_data_o, gl);
                    end
                end
                if (mem_req_o) begin
                    check("mem_align", 256'(mem_addr_o[4:0]), 256'(0));
                    if (prev_req && !prev_ack)
                        check("mem_stable", 256'(mem_write_o == prev_wr && mem_addr_o == prev_addr && mem_data_o == prev_data), 256'(1));
                    if (mem_ack_i && mem_write_o) check("wb_line", mem_data_o, gold_line(mem_addr_o));
                    if (mem_ack_i && !mem_write_o) check("refill_addr", 256'(mem_addr_o), 256'(la));
                end
                if (cpu_stall_o) begin
                    stall_n++;
                    if (mem_req_o) req_n++;
                end else if (prev_stall) begin
                    check("miss_latency", 256'(stall_n), 256'(req_n + 3));
                    stall_n = 0;
                    req_n   = 0;
                end
                prev_req = mem_req_o; prev_ack = mem_ack_i; prev_stall = cpu_stall_o;
                prev_wr = mem_write_o; prev_addr = mem_addr_o; prev_data = mem_data_o;
            end
        end
    end

    task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int st, output logic [24:0] tg, output logic [255:0] ln);
        int n;
        st = 0;
        cpu_req_i = 1; cpu_write_i = wr; cpu_addr_i = a; cpu_data_i = d;
        for (n = 0; n < 300; n++) begin
            @(negedge clk_i);
            if (!cpu_stall_o) break;
            st++;
        end
        check("access_timeout", 256'(n < 300), 256'(1));
        rd = cpu_data_o; tg = sram_tag_o; ln = sram_data_o;
        @(posedge clk_i);
        #1;
        cpu_req_i = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [31:0]  rd;
        logic [24:0]  tg;
        logic [255:0] ln, pre;
        int           st, n;
        clk_i = 0; rst_i = 1; cpu_req_i = 0; cpu_write_i = 0; cpu_addr_i = 0; cpu_data_i = 0; mem_data_i = '0;
        pre = dflt(32'h40);
        pre[31:0] = 32'hDEADBEEF;
        mem[32'h40] = pre;
        gold = mem;
        @(negedge clk_i);
        check("rst_mem_req", 256'(mem_req_o), 256'(0));
        check("rst_mem_write", 256'(mem_write_o), 256'(0));
        check("rst_mem_addr", 256'(mem_addr_o), 256'(0));
        check("rst_mem_data", mem_data_o, 256'(0));
        check("rst_stall", 256'(cpu_stall_o), 256'(0));
        check("rst_sram_wr", 256'(sram_write_o), 256'(0));
        check("rst_cpu_data", 256'(cpu_data_o), 256'(0));
        @(posedge clk_i);
        #1;
        rst_i = 0;

        txq.delete();
        access(0, 32'h40, 0, rd, st, tg, ln);
        check("cold_data", 256'(rd), 256'(32'hDEADBEEF));
        check("cold_stalls", 256'(st), 256'(9));
        check("cold_txn_n", 256'(txq.size()), 256'(1));
        if (txq.size() == 1) check("cold_txn", 256'({txq[0].w, txq[0].a}), 256'({1'b0, 32'h40}));

        txq.delete();
        access(0, 32'h44, 0, rd, st, tg, ln);
        check("hit_data", 256'(rd), 256'(32'hA000_0044));
        check("hit_stalls", 256'(st), 256'(0));
        check("hit_txn_n", 256'(txq.size()), 256'(0));

        access(1, 32'h48, 32'hCAFEF00D, rd, st, tg, ln);
        check("st_stalls", 256'(st), 256'(0));
        check("st_tag", 256'(tg), 256'(25'h180_0000));
        check("st_word2", 256'(ln[95:64]), 256'(32'hCAFEF00D));
        check("st_word1", 256'(ln[63:32]), 256'(32'hA000_0044));

        txq.delete();
        access(0, 32'h240, 0, rd, st, tg, ln);
        check("t1_data", 256'(rd), 256'(32'hA000_0240));
        check("t1_stalls", 256'(st), 256'(9));
        check("t1_txn_n", 256'(txq.size()), 256'(1));

        txq.delete();
        access(0, 32'h440, 0, rd, st, tg, ln);
        check("evict_data", 256'(rd), 256'(32'hA000_0440));
        check("evict_stalls", 256'(st), 256'(16));
        check("evict_txn_n", 256'(txq.size()), 256'(2));
        if (txq.size() == 2) begin
            check("evict_wb", 256'({txq[0].w, txq[0].a, txq[0].l[95:64]}), 256'({1'b1, 32'h40, 32'hCAFEF00D}));
            check("evict_refill", 256'({txq[1].w, txq[1].a}), 256'({1'b0, 32'h440}));
        end

        spur = 1;
        @(posedge clk_i);
        #1;
        spur = 0;
        txq.delete();
        access(0, 32'h444, 0, rd, st, tg, ln);
        check("spur_hit_data", 256'(rd), 256'(32'hA000_0444));
        check("spur_hit_stalls", 256'(st), 256'(0));
        check("spur_txn_n", 256'(txq.size()), 256'(0));

        ack_delay = 0;
        txq.delete();
        access(0, 32'h48, 0, rd, st, tg, ln);
        check("fast_data", 256'(rd), 256'(32'hCAFEF00D));
        check("fast_stalls", 256'(st), 256'(4));
        check("fast_txn_n", 256'(txq.size()), 256'(1));

        ack_delay = 2;
        access(1, 32'h80, 32'h1111_2222, rd, st, tg, ln);
        access(1, 32'h280, 32'h3333_4444, rd, st, tg, ln);
        ack_delay = 30;
        txq.delete();
        cpu_req_i = 1; cpu_write_i = 0; cpu_addr_i = 32'h480;
        for (n = 0; n < 50; n++) begin
            @(negedge clk_i);
            if (mem_req_o && mem_write_o) break;
        end
        check("wb_started", 256'(n < 50), 256'(1));
        check("wb_addr", 256'(mem_addr_o), 256'(32'h80));
        @(posedge clk_i);
        #2;
        rst_i = 1;
        #1;
        check("abort_mem_req", 256'(mem_req_o), 256'(0));
        check("abort_stall", 256'(cpu_stall_o), 256'(0));
        cpu_req_i = 0;
        @(posedge clk_i);
        #1;
        rst_i = 0;
        check("abort_txn_n", 256'(txq.size()), 256'(0));

        ack_delay = 3;
        txq.delete();
        access(0, 32'h40, 0, rd, st, tg, ln);
        check("post_rst_data", 256'(rd), 256'(32'hDEADBEEF));
        check("post_rst_stalls", 256'(st), 256'(7));
        check("post_rst_txn_n", 256'(txq.size()), 256'(1));
        if (txq.size() == 1) check("post_rst_txn", 256'({txq[0].w, txq[0].a}), 256'({1'b0, 32'h40}));
        access(0, 32'h48, 0, rd, st, tg, ln);
        check("post_rst_hit", 256'(rd), 256'(32'hCAFEF00D));
        check("post_rst_hit_stalls", 256'(st), 256'(0));

        repeat (2) @(posedge clk_i);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
